// File: rtl/game_pkg.sv
// Shared definitions for the dot-matrix game round logic.
//   state_t       : round state encoding (IDLE/PLAY/OVER)
//   POSE_W        : width of a boss/player pose code
//   VAL_W         : width of the score/time display values
//   DEF_GAME_SECS : default round length in seconds
//   DEF_MAX_SCORE : default score saturation value
//   DISP_LIMIT    : largest value the two-digit 7-segment display can show
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int unsigned POSE_W        = 2;
  localparam int unsigned VAL_W         = 7;
  localparam int unsigned DEF_GAME_SECS = 30;
  localparam int unsigned DEF_MAX_SCORE = 99;
  localparam int unsigned DISP_LIMIT    = 99;

endpackage

// File: rtl/tick_prescaler.sv
// Game-second prescaler: counts 0..SEC_DIV-1 while enabled and pulses o_tick
// in the cycle the count wraps back to 0.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   i_en   in  count enable
//   i_clr  in  synchronous clear (dominates enable)
//   o_tick out one-cycle pulse at terminal count
module tick_prescaler #(
  parameter int unsigned SEC_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CNT_W = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(SEC_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && !i_clr && (r_cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the boss/player dot-matrix game: IDLE/PLAY/OVER state
// machine, per-second countdown and match-hold scoring timer.
//   clk          in  system clock
//   reset        in  asynchronous active-low reset
//   go           in  start/restart request (level, rising edge used)
//   boss_state   in  boss current pose
//   player_state in  player current pose
//   start        out high in PLAY and OVER
//   finish       out high in OVER
//   correct      out PLAY and poses equal
//   add          out one-cycle score pulse
//   sec_tick     out one-cycle pulse per game second (PLAY only)
//   time_left    out remaining seconds
//   score        out points this round (saturating)
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned SEC_DIV     = 50_000_000,
  parameter int unsigned GAME_SECS   = DEF_GAME_SECS,
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned MAX_SCORE   = DEF_MAX_SCORE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [POSE_W-1:0] boss_state,
  input  logic [POSE_W-1:0] player_state,
  output logic              start,
  output logic              finish,
  output logic              correct,
  output logic              add,
  output logic              sec_tick,
  output logic [VAL_W-1:0]  time_left,
  output logic [VAL_W-1:0]  score
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [VAL_W-1:0]  SECS_V    = VAL_W'(GAME_SECS);
  localparam logic [VAL_W-1:0]  MAX_V     = VAL_W'(MAX_SCORE);

  state_t             r_state;
  state_t             w_next;
  logic               r_go_q;
  logic               r_live;
  logic [HOLD_W-1:0]  r_hold;
  logic               r_add;
  logic [VAL_W-1:0]   r_time;
  logic [VAL_W-1:0]   r_score;
  logic               w_play;
  logic               w_tick;
  logic               w_go_rise;
  logic               w_load;
  logic               w_last;

  // r_live is low only in the first cycle after reset release, so a go held
  // high across reset is not mistaken for a fresh press.
  assign w_go_rise = go && !r_go_q && r_live;
  assign w_play    = (r_state == PLAY);
  assign w_load    = w_go_rise && !w_play;
  assign w_last    = w_tick && (r_time == VAL_W'(1));

  tick_prescaler #(
    .SEC_DIV (SEC_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (reset),
    .i_en   (w_play),
    .i_clr  (!w_play),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    start   = 1'b0;
    finish  = 1'b0;
    correct = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go_rise) w_next = PLAY;
      end
      PLAY: begin
        start   = 1'b1;
        correct = (boss_state == player_state);
        if (w_last) w_next = OVER;
      end
      OVER: begin
        start  = 1'b1;
        finish = 1'b1;
        if (w_go_rise) w_next = PLAY;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_go_q  <= 1'b0;
      r_live  <= 1'b0;
      r_hold  <= '0;
      r_add   <= 1'b0;
      r_time  <= SECS_V;
      r_score <= '0;
    end else begin
      r_go_q <= go;
      r_live <= 1'b1;

      if (w_load)                         r_time <= SECS_V;
      else if (w_tick && r_time != '0)    r_time <= r_time - VAL_W'(1);

      if (w_load)                         r_score <= '0;
      else if (r_add && r_score < MAX_V)  r_score <= r_score + VAL_W'(1);

      // A match completing in the final PLAY cycle would pulse add in OVER,
      // so that point is dropped and the timer cleared instead.
      if (correct && !w_last) begin
        if (r_hold == HOLD_TERM) begin
          r_hold <= '0;
          r_add  <= 1'b1;
        end else begin
          r_hold <= r_hold + HOLD_W'(1);
          r_add  <= 1'b0;
        end
      end else begin
        r_hold <= '0;
        r_add  <= 1'b0;
      end
    end
  end

  assign add       = r_add;
  assign sec_tick  = w_tick;
  assign time_left = r_time;
  assign score     = r_score;

  a_disp_limits: assert property (@(posedge clk)
    (GAME_SECS >= 1) && (GAME_SECS <= DISP_LIMIT) && (MAX_SCORE <= DISP_LIMIT));

endmodule
